// File: rtl/ablauf_steuerung.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory, writeback.
// All control strobes are registered from the next-state decode.
module ablauf_steuerung (
  input  logic        Takt,
  input  logic        Reset,
  input  logic        Anhalten,
  input  logic        SpeicherBereit,
  input  logic        AluFertig,
  input  logic        Null,
  input  logic        LoadBefehl,
  input  logic        StoreBefehl,
  input  logic        UnbedingterSprungBefehl,
  input  logic        BedingterSprungBefehl,
  input  logic        Sprungbedingung,
  input  logic        JALBefehl,
  input  logic [5:0]  ZielRegister,
  output logic        BefehlHolen,
  output logic        DekodierSignal,
  output logic        AluStart,
  output logic        SpeicherLesen,
  output logic        SpeicherSchreiben,
  output logic        RegisterSchreiben,
  output logic        PCInkrement,
  output logic        PCLaden,
  output logic        Fehler,
  output logic [2:0]  Zustand,
  output logic [31:0] BefehlZaehler
);

  typedef enum logic [2:0] {
    LEERLAUF   = 3'd0,
    HOLEN      = 3'd1,
    DEKODIEREN = 3'd2,
    LESEN      = 3'd3,
    AUSFUEHREN = 3'd4,
    SPEICHER   = 3'd5,
    ZURUECK    = 3'd6,
    FEHLER     = 3'd7
  } zustand_t;

  zustand_t    r_zustand;
  zustand_t    w_naechster;
  logic        r_bereit;
  logic [7:0]  r_wachhund;
  logic [31:0] r_zaehler;

  logic r_holen, r_dek, r_alu, r_lesen, r_schreiben;
  logic r_reg, r_pcinc, r_pcladen, r_fehler;

  logic w_holen, w_dek, w_alu, w_lesen, w_schreiben;
  logic w_reg, w_pcinc, w_pcladen, w_fehler;
  logic w_sprung, w_rs, w_zur, w_warten;

  always_comb begin
    w_naechster = r_zustand;
    w_sprung    = UnbedingterSprungBefehl
                | (BedingterSprungBefehl & (Null == Sprungbedingung));
    w_rs        = (ZielRegister != 6'd0) & ~StoreBefehl
                & ~BedingterSprungBefehl
                & (~UnbedingterSprungBefehl | JALBefehl);
    w_warten    = (r_zustand == HOLEN) | (r_zustand == SPEICHER);
    case (r_zustand)
      LEERLAUF:
        if (r_bereit && !Anhalten) w_naechster = HOLEN;
      HOLEN:
        if (SpeicherBereit)            w_naechster = DEKODIEREN;
        else if (r_wachhund == 8'hFF)  w_naechster = FEHLER;
      DEKODIEREN: w_naechster = LESEN;
      LESEN:      w_naechster = AUSFUEHREN;
      AUSFUEHREN:
        if (AluFertig)
          w_naechster = (LoadBefehl || StoreBefehl) ? SPEICHER : ZURUECK;
      SPEICHER:
        if (SpeicherBereit)            w_naechster = ZURUECK;
        else if (r_wachhund == 8'hFF)  w_naechster = FEHLER;
      ZURUECK:
        w_naechster = Anhalten ? LEERLAUF : HOLEN;
      FEHLER:     w_naechster = FEHLER;
      default:    w_naechster = LEERLAUF;
    endcase

    w_zur       = (w_naechster == ZURUECK);
    w_holen     = (w_naechster == HOLEN);
    w_dek       = (w_naechster == DEKODIEREN);
    w_alu       = (w_naechster == AUSFUEHREN) && (r_zustand != AUSFUEHREN);
    w_lesen     = (w_naechster == SPEICHER) && LoadBefehl;
    // load wins if a malformed decode flags both
    w_schreiben = (w_naechster == SPEICHER) && StoreBefehl && !LoadBefehl;
    w_reg       = w_zur & w_rs;
    w_pcladen   = w_zur & w_sprung;
    w_pcinc     = w_zur & ~w_sprung;
    w_fehler    = (w_naechster == FEHLER);
  end

  always_ff @(posedge Takt or posedge Reset) begin
    if (Reset) begin
      r_zustand   <= LEERLAUF;
      r_bereit    <= 1'b0;
      r_wachhund  <= 8'd0;
      r_zaehler   <= 32'd0;
      r_holen     <= 1'b0;
      r_dek       <= 1'b0;
      r_alu       <= 1'b0;
      r_lesen     <= 1'b0;
      r_schreiben <= 1'b0;
      r_reg       <= 1'b0;
      r_pcinc     <= 1'b0;
      r_pcladen   <= 1'b0;
      r_fehler    <= 1'b0;
    end else begin
      r_zustand   <= w_naechster;
      r_bereit    <= 1'b1;
      // counts only while waiting in place; any state change restarts it
      if (w_warten && (w_naechster == r_zustand))
        r_wachhund <= r_wachhund + 8'd1;
      else
        r_wachhund <= 8'd0;
      if (r_zustand == ZURUECK)
        r_zaehler <= r_zaehler + 32'd1;
      r_holen     <= w_holen;
      r_dek       <= w_dek;
      r_alu       <= w_alu;
      r_lesen     <= w_lesen;
      r_schreiben <= w_schreiben;
      r_reg       <= w_reg;
      r_pcinc     <= w_pcinc;
      r_pcladen   <= w_pcladen;
      r_fehler    <= w_fehler;
    end
  end

  assign Zustand           = r_zustand;
  assign BefehlZaehler     = r_zaehler;
  assign BefehlHolen       = r_holen;
  assign DekodierSignal    = r_dek;
  assign AluStart          = r_alu;
  assign SpeicherLesen     = r_lesen;
  assign SpeicherSchreiben = r_schreiben;
  assign RegisterSchreiben = r_reg;
  assign PCInkrement       = r_pcinc;
  assign PCLaden           = r_pcladen;
  assign Fehler            = r_fehler;

endmodule

// File: tb/tb_ablauf_steuerung.sv
// Directed testbench for ablauf_steuerung.
// Strobe vector order: Holen Dek Alu Lesen Schreiben Reg Inc Laden Fehler.
module tb_ablauf_steuerung;

  logic        Takt = 1'b0;
  logic        Reset;
  logic        Anhalten, SpeicherBereit, AluFertig, Null;
  logic        LoadBefehl, StoreBefehl;
  logic        UnbedingterSprungBefehl, BedingterSprungBefehl;
  logic        Sprungbedingung, JALBefehl;
  logic [5:0]  ZielRegister;
  logic        BefehlHolen, DekodierSignal, AluStart;
  logic        SpeicherLesen, SpeicherSchreiben, RegisterSchreiben;
  logic        PCInkrement, PCLaden, Fehler;
  logic [2:0]  Zustand;
  logic [31:0] BefehlZaehler;
  logic [8:0]  w_strobes;

  int errors = 0;
  int checks = 0;

  localparam logic [8:0] S0 = 9'b000000000;
  localparam logic [8:0] SH = 9'b100000000;
  localparam logic [8:0] SD = 9'b010000000;
  localparam logic [8:0] SA = 9'b001000000;
  localparam logic [8:0] SL = 9'b000100000;
  localparam logic [8:0] SS = 9'b000010000;
  localparam logic [8:0] SR = 9'b000001000;
  localparam logic [8:0] SI = 9'b000000100;
  localparam logic [8:0] SP = 9'b000000010;
  localparam logic [8:0] SF = 9'b000000001;

  always #5 Takt = ~Takt;

  assign w_strobes = {BefehlHolen, DekodierSignal, AluStart,
                      SpeicherLesen, SpeicherSchreiben,
                      RegisterSchreiben, PCInkrement, PCLaden, Fehler};

  ablauf_steuerung dut (
    .Takt(Takt), .Reset(Reset), .Anhalten(Anhalten),
    .SpeicherBereit(SpeicherBereit), .AluFertig(AluFertig), .Null(Null),
    .LoadBefehl(LoadBefehl), .StoreBefehl(StoreBefehl),
    .UnbedingterSprungBefehl(UnbedingterSprungBefehl),
    .BedingterSprungBefehl(BedingterSprungBefehl),
    .Sprungbedingung(Sprungbedingung), .JALBefehl(JALBefehl),
    .ZielRegister(ZielRegister),
    .BefehlHolen(BefehlHolen), .DekodierSignal(DekodierSignal),
    .AluStart(AluStart), .SpeicherLesen(SpeicherLesen),
    .SpeicherSchreiben(SpeicherSchreiben),
    .RegisterSchreiben(RegisterSchreiben),
    .PCInkrement(PCInkrement), .PCLaden(PCLaden), .Fehler(Fehler),
    .Zustand(Zustand), .BefehlZaehler(BefehlZaehler)
  );

  task automatic step();
    @(posedge Takt);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(posedge Takt);
    #1;
    Reset = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    @(posedge Takt);
    @(posedge Takt);
    #1;
    checks++;
    if ({Zustand, w_strobes, BefehlZaehler} !== 44'd0) begin
      errors++;
      $display("FAIL reset_hold: got z=%0d s=%b cnt=%0d want 0",
               Zustand, w_strobes, BefehlZaehler);
    end
    Reset = 1'b0;
    step();
    checks++;
    if ({Zustand, w_strobes} !== {3'd0, S0}) begin
      errors++;
      $display("FAIL reset_idle1: got z=%0d s=%b want z=0 s=%b",
               Zustand, w_strobes, S0);
    end
    step();
    checks++;
    if ({Zustand, w_strobes} !== {3'd1, SH}) begin
      errors++;
      $display("FAIL reset_fetch: got z=%0d s=%b want z=1 s=%b",
               Zustand, w_strobes, SH);
    end
  endtask

  task automatic test_alu();
    logic [11:0] e [6];
    ZielRegister = 6'd5;
    e[0] = {3'd1, SH}; e[1] = {3'd2, SD}; e[2] = {3'd3, S0};
    e[3] = {3'd4, SA}; e[4] = {3'd6, SR | SI}; e[5] = {3'd1, SH};
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      checks++;
      if ({Zustand, w_strobes} !== e[i]) begin
        errors++;
        $display("FAIL alu c%0d: got %h want %h", i,
                 {Zustand, w_strobes}, e[i]);
      end
    end
    checks++;
    if (BefehlZaehler !== 32'd1) begin
      errors++;
      $display("FAIL alu_count: got %0d want 1", BefehlZaehler);
    end
  endtask

  task automatic test_load();
    logic [11:0] e [10];
    LoadBefehl   = 1'b1;
    ZielRegister = 6'd7;
    e[0] = {3'd1, SH}; e[1] = {3'd2, SD}; e[2] = {3'd3, S0};
    e[3] = {3'd4, SA}; e[4] = {3'd5, SL}; e[5] = {3'd5, SL};
    e[6] = {3'd5, SL}; e[7] = {3'd5, SL}; e[8] = {3'd6, SR | SI};
    e[9] = {3'd1, SH};
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      checks++;
      if ({Zustand, w_strobes} !== e[i]) begin
        errors++;
        $display("FAIL load c%0d: got %h want %h", i,
                 {Zustand, w_strobes}, e[i]);
      end
      if (i == 3) SpeicherBereit = 1'b0;
      if (i == 7) SpeicherBereit = 1'b1;
    end
    LoadBefehl = 1'b0;
    checks++;
    if (BefehlZaehler !== 32'd2) begin
      errors++;
      $display("FAIL load_count: got %0d want 2", BefehlZaehler);
    end
  endtask

  task automatic test_branch();
    logic [11:0] e [13];
    BedingterSprungBefehl = 1'b1;
    Sprungbedingung       = 1'b1;
    Null                  = 1'b1;
    ZielRegister          = 6'd5;
    e[0]  = {3'd1, SH}; e[1]  = {3'd2, SD}; e[2]  = {3'd3, S0};
    e[3]  = {3'd4, SA}; e[4]  = {3'd4, S0}; e[5]  = {3'd4, S0};
    e[6]  = {3'd6, SP}; e[7]  = {3'd1, SH}; e[8]  = {3'd2, SD};
    e[9]  = {3'd3, S0}; e[10] = {3'd4, SA}; e[11] = {3'd6, SI};
    e[12] = {3'd1, SH};
    for (int i = 0; i < 13; i++) begin
      if (i > 0) step();
      checks++;
      if ({Zustand, w_strobes} !== e[i]) begin
        errors++;
        $display("FAIL branch c%0d: got %h want %h", i,
                 {Zustand, w_strobes}, e[i]);
      end
      if (i == 2) AluFertig = 1'b0;
      if (i == 5) AluFertig = 1'b1;
      if (i == 7) Null = 1'b0;
    end
    BedingterSprungBefehl = 1'b0;
    Sprungbedingung       = 1'b0;
    checks++;
    if (BefehlZaehler !== 32'd4) begin
      errors++;
      $display("FAIL branch_count: got %0d want 4", BefehlZaehler);
    end
  endtask

  task automatic test_jump_halt();
    logic [11:0] e [18];
    UnbedingterSprungBefehl = 1'b1;
    JALBefehl               = 1'b1;
    ZielRegister            = 6'd31;
    e[0]  = {3'd1, SH}; e[1]  = {3'd2, SD}; e[2]  = {3'd3, S0};
    e[3]  = {3'd4, SA}; e[4]  = {3'd6, SR | SP}; e[5] = {3'd1, SH};
    e[6]  = {3'd2, SD}; e[7]  = {3'd3, S0}; e[8]  = {3'd4, SA};
    e[9]  = {3'd6, SP}; e[10] = {3'd0, S0}; e[11] = {3'd0, S0};
    e[12] = {3'd1, SH}; e[13] = {3'd2, SD}; e[14] = {3'd3, S0};
    e[15] = {3'd4, SA}; e[16] = {3'd6, SI}; e[17] = {3'd1, SH};
    for (int i = 0; i < 18; i++) begin
      if (i > 0) step();
      checks++;
      if ({Zustand, w_strobes} !== e[i]) begin
        errors++;
        $display("FAIL jump c%0d: got %h want %h", i,
                 {Zustand, w_strobes}, e[i]);
      end
      if (i == 5) begin
        JALBefehl    = 1'b0;
        ZielRegister = 6'd3;
      end
      if (i == 9) Anhalten = 1'b1;
      if (i == 11) Anhalten = 1'b0;
      if (i == 12) begin
        UnbedingterSprungBefehl = 1'b0;
        ZielRegister            = 6'd0;
      end
    end
    checks++;
    if (BefehlZaehler !== 32'd7) begin
      errors++;
      $display("FAIL jump_count: got %0d want 7", BefehlZaehler);
    end
  endtask

  task automatic test_reset_store();
    logic [11:0] e [6];
    StoreBefehl  = 1'b1;
    ZielRegister = 6'd9;
    e[0] = {3'd1, SH}; e[1] = {3'd2, SD}; e[2] = {3'd3, S0};
    e[3] = {3'd4, SA}; e[4] = {3'd5, SS}; e[5] = {3'd5, SS};
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      checks++;
      if ({Zustand, w_strobes} !== e[i]) begin
        errors++;
        $display("FAIL store c%0d: got %h want %h", i,
                 {Zustand, w_strobes}, e[i]);
      end
      if (i == 3) SpeicherBereit = 1'b0;
    end
    #3;
    Reset = 1'b1;
    #1;
    checks++;
    if ({Zustand, w_strobes, BefehlZaehler} !== 44'd0) begin
      errors++;
      $display("FAIL store_reset: got z=%0d s=%b cnt=%0d want 0",
               Zustand, w_strobes, BefehlZaehler);
    end
    StoreBefehl    = 1'b0;
    SpeicherBereit = 1'b1;
  endtask

  task automatic test_watchdog();
    int bad;
    SpeicherBereit = 1'b0;
    ZielRegister   = 6'd5;
    do_reset();
    bad = 0;
    for (int i = 1; i <= 256; i++) begin
      if ({Zustand, w_strobes} !== {3'd1, SH}) bad++;
      step();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL wd_wait: got %0d bad fetch cycles want 0", bad);
    end
    checks++;
    if ({Zustand, w_strobes} !== {3'd7, SF}) begin
      errors++;
      $display("FAIL wd_error: got z=%0d s=%b want z=7 s=%b",
               Zustand, w_strobes, SF);
    end
    SpeicherBereit = 1'b1;
    step();
    step();
    checks++;
    if ({Zustand, w_strobes, BefehlZaehler} !== {3'd7, SF, 32'd0}) begin
      errors++;
      $display("FAIL wd_stuck: got z=%0d s=%b cnt=%0d want z=7 s=%b 0",
               Zustand, w_strobes, BefehlZaehler, SF);
    end
    SpeicherBereit = 1'b0;
    do_reset();
    for (int i = 1; i < 256; i++) step();
    checks++;
    if ({Zustand, w_strobes} !== {3'd1, SH}) begin
      errors++;
      $display("FAIL wd_c256: got z=%0d s=%b want z=1 s=%b",
               Zustand, w_strobes, SH);
    end
    SpeicherBereit = 1'b1;
    step();
    checks++;
    if ({Zustand, w_strobes} !== {3'd2, SD}) begin
      errors++;
      $display("FAIL wd_late_ready: got z=%0d s=%b want z=2 s=%b",
               Zustand, w_strobes, SD);
    end
  endtask

  initial begin
    Reset                   = 1'b1;
    Anhalten                = 1'b0;
    SpeicherBereit          = 1'b1;
    AluFertig               = 1'b1;
    Null                    = 1'b0;
    LoadBefehl              = 1'b0;
    StoreBefehl             = 1'b0;
    UnbedingterSprungBefehl = 1'b0;
    BedingterSprungBefehl   = 1'b0;
    Sprungbedingung         = 1'b0;
    JALBefehl               = 1'b0;
    ZielRegister            = 6'd0;
    test_reset();
    test_alu();
    test_load();
    test_branch();
    test_jump_halt();
    test_reset_store();
    test_watchdog();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
